// File: rtl/encoder32x5_scan.sv
// Sequential 32-to-5 encoder: captures a multi-hot vector and drains the index of
// each set bit, lowest first, one per out_valid/out_ready handshake.
module encoder32x5_scan #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic             busy,
    output logic [IDX_W:0]   count,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             done_q, done_d;
    logic [IDX_W-1:0] lsb_idx;
    logic [IDX_W:0]   pop_cnt;
    logic [WIDTH-1:0] pend_cleared;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        lsb_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pend_q[i]) lsb_idx = IDX_W'(i);
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_cnt = pop_cnt + {{IDX_W{1'b0}}, pend_q[i]};
        end
    end

    // x & (x-1) drops exactly the lowest set bit, i.e. pend[lsb_idx].
    assign pend_cleared = pend_q & (pend_q - {{(WIDTH-1){1'b0}}, 1'b1});

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    if (in_vec != '0) begin
                        pend_d  = in_vec;
                        state_d = EMIT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pend_d = pend_cleared;
                    if (pend_cleared == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == EMIT);
    assign out_valid = busy;
    assign out_idx   = busy ? lsb_idx : '0;
    assign count     = pop_cnt;
    assign done      = done_q;

endmodule
